// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready handshake feeding the instruction-memory loader.
// The producer drives valid/data and the loader answers with ready.
interface imem_loader_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (output byte_valid, output byte_data, input byte_ready);
    modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: parses a base/count header, packs big-endian
// words, writes them consecutively, verifies an XOR checksum and holds the CPU until success.
module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    imem_loader_if.slave        stream,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [31:0]         imem_wdata,
    output logic [ADDR_W:0]     words_written,
    output logic                cpu_hold,
    output logic                done,
    output logic                error
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        HDR_BASE,
        HDR_CNT,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [7:0]         count_q, count_d;
    logic [7:0]         acc_q, acc_d;
    logic [1:0]         lane_q, lane_d;
    logic [23:0]        part_q, part_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [ADDR_W:0]    ww_q, ww_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               ready_q, ready_d;
    logic               hold_q, hold_d;
    logic               xfer;
    logic [ADDR_W+1:0]  span;

    assign xfer = stream.byte_valid & ready_q;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        acc_d   = acc_q;
        lane_d  = lane_q;
        part_d  = part_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ww_d    = ww_q;
        done_d  = done_q;
        error_d = error_q;
        span    = {2'b00, base_q} + (ADDR_W+2)'(stream.byte_data);

        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = HDR_BASE;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    ww_d    = '0;
                    acc_d   = '0;
                    lane_d  = '0;
                end
            end
            HDR_BASE: begin
                if (xfer) begin
                    base_d  = stream.byte_data[ADDR_W-1:0];
                    acc_d   = acc_q ^ stream.byte_data;
                    state_d = HDR_CNT;
                end
            end
            HDR_CNT: begin
                if (xfer) begin
                    count_d = stream.byte_data;
                    acc_d   = acc_q ^ stream.byte_data;
                    // The range check wraps at ADDR_W+2 bits, matching the header arithmetic.
                    if (span > (ADDR_W+2)'(DEPTH)) begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end else if (stream.byte_data == 8'd0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    acc_d = acc_q ^ stream.byte_data;
                    if (lane_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = base_q + ww_q[ADDR_W-1:0];
                        wdata_d = {part_q, stream.byte_data};
                        ww_d    = ww_q + 1'b1;
                        lane_d  = '0;
                        if (8'(ww_q) + 8'd1 == count_q) begin
                            state_d = CHECK;
                        end
                    end else begin
                        part_d = {part_q[15:0], stream.byte_data};
                        lane_d = lane_q + 2'd1;
                    end
                end
            end
            CHECK: begin
                if (xfer) begin
                    if (stream.byte_data == acc_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake and hold are registered from the upcoming state so they never depend on byte_valid.
        ready_d = (state_d == HDR_BASE) || (state_d == HDR_CNT) ||
                  (state_d == DATA) || (state_d == CHECK);
        hold_d  = (state_d != DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            count_q <= '0;
            acc_q   <= '0;
            lane_q  <= '0;
            part_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ww_q    <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            ready_q <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            lane_q  <= lane_d;
            part_q  <= part_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ww_q    <= ww_d;
            done_q  <= done_d;
            error_q <= error_d;
            ready_q <= ready_d;
            hold_q  <= hold_d;
        end
    end

    assign stream.byte_ready = ready_q;
    assign imem_we           = we_q;
    assign imem_addr         = addr_q;
    assign imem_wdata        = wdata_q;
    assign words_written     = ww_q;
    assign cpu_hold          = hold_q;
    assign done              = done_q;
    assign error             = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a session-level byte model predicts every output each
// cycle, and literal expectations pin the captured writes and flags of each scenario.
module tb_imem_loader;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   words_written;
    logic              cpu_hold;
    logic              done;
    logic              error;

    imem_loader_if stream ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stream        (stream.slave),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .words_written (words_written),
        .cpu_hold      (cpu_hold),
        .done          (done),
        .error         (error)
    );

    always #5 clk = ~clk;

    int          nChecks = 0;
    int          nFail   = 0;
    bit          cmpEn   = 1'b0;
    logic [31:0] seenAddr[$];
    logic [31:0] seenData[$];

    logic [7:0] s1 [0:10] = '{8'h19, 8'h02, 8'h00, 8'h22, 8'h18, 8'h20,
                              8'h01, 8'h23, 8'h20, 8'h22, 8'h21};

    // Session model: tracks the accepted bytes of the current load and derives outputs from them.
    bit          mActive = 1'b0;
    int          mNb     = 0;
    int          mBase   = 0;
    int          mCnt    = 0;
    logic [7:0]  mAcc    = '0;
    logic [31:0] mWord   = '0;
    int          mWcount = 0;
    bit          mDone   = 1'b0;
    bit          mErr    = 1'b0;
    bit          mWe     = 1'b0;
    int          mAddr   = 0;
    logic [31:0] mData   = '0;
    logic [7:0]  mByte;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mActive = 0; mNb = 0; mAcc = '0; mWcount = 0;
            mDone = 0; mErr = 0; mWe = 0; mAddr = 0; mData = '0;
        end else begin
            mWe = 0;
            if (!mActive) begin
                if (start) begin
                    mActive = 1; mNb = 0; mAcc = '0; mWcount = 0; mDone = 0; mErr = 0;
                end
            end else if (stream.byte_valid) begin
                mByte = stream.byte_data;
                if (mNb == 0) begin
                    mBase = int'(mByte) % 64;
                    mAcc  = mAcc ^ mByte;
                end else if (mNb == 1) begin
                    mCnt = int'(mByte);
                    mAcc = mAcc ^ mByte;
                    if (((mBase + mCnt) % 256) > 64) begin
                        mActive = 0;
                        mErr    = 1;
                    end
                end else if (mNb - 2 < 4 * mCnt) begin
                    mAcc  = mAcc ^ mByte;
                    mWord = {mWord[23:0], mByte};
                    if ((mNb - 2) % 4 == 3) begin
                        mWe     = 1;
                        mAddr   = (mBase + mWcount) % 64;
                        mData   = mWord;
                        mWcount = mWcount + 1;
                    end
                end else begin
                    mActive = 0;
                    if (mByte == mAcc) mDone = 1;
                    else               mErr  = 1;
                end
                mNb = mNb + 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmpEn) begin
            checkOutput("byte_ready",    32'(stream.byte_ready), 32'(mActive));
            checkOutput("imem_we",       32'(imem_we),           32'(mWe));
            checkOutput("imem_addr",     32'(imem_addr),         32'(mAddr));
            checkOutput("imem_wdata",    imem_wdata,             mData);
            checkOutput("words_written", 32'(words_written),     32'(mWcount));
            checkOutput("done",          32'(done),              32'(mDone));
            checkOutput("error",         32'(error),             32'(mErr));
            checkOutput("cpu_hold",      32'(cpu_hold),          32'(!mDone));
            if (imem_we === 1'b1) begin
                seenAddr.push_back(32'(imem_addr));
                seenData.push_back(imem_wdata);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        idle(1);
        start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit gaps);
        bit taken  = 1'b0;
        int budget = 0;
        while (!taken && budget < 40) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                stream.byte_valid = 1'b0;
            end else begin
                stream.byte_valid = 1'b1;
                stream.byte_data  = b;
            end
            @(negedge clk);
            taken = stream.byte_valid && stream.byte_ready;
            idle(1);
            budget++;
        end
        stream.byte_valid = 1'b0;
        if (!taken) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL byte_accept: byte 0x%0h not accepted, expected acceptance within 40 cycles", b);
        end
    endtask

    task automatic clearSeen();
        seenAddr.delete();
        seenData.delete();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_byte_ready"}, 32'(stream.byte_ready), 32'd0);
        checkOutput({tag, "_imem_we"},    32'(imem_we),           32'd0);
        checkOutput({tag, "_imem_addr"},  32'(imem_addr),         32'd0);
        checkOutput({tag, "_imem_wdata"}, imem_wdata,             32'd0);
        checkOutput({tag, "_words"},      32'(words_written),     32'd0);
        checkOutput({tag, "_done"},       32'(done),              32'd0);
        checkOutput({tag, "_error"},      32'(error),             32'd0);
        checkOutput({tag, "_cpu_hold"},   32'(cpu_hold),          32'd1);
    endtask

    task automatic checkGoodLoad(input string tag);
        checkOutput({tag, "_nwrites"}, 32'(seenAddr.size()), 32'd2);
        if (seenAddr.size() >= 2) begin
            checkOutput({tag, "_addr0"}, seenAddr[0], 32'd25);
            checkOutput({tag, "_data0"}, seenData[0], 32'h0022_1820);
            checkOutput({tag, "_addr1"}, seenAddr[1], 32'd26);
            checkOutput({tag, "_data1"}, seenData[1], 32'h0123_2022);
        end
        checkOutput({tag, "_words"},    32'(words_written), 32'd2);
        checkOutput({tag, "_done"},     32'(done),          32'd1);
        checkOutput({tag, "_error"},    32'(error),         32'd0);
        checkOutput({tag, "_cpu_hold"}, 32'(cpu_hold),      32'd0);
    endtask

    initial begin
        rst_n             = 1'b1;
        start             = 1'b0;
        stream.byte_valid = 1'b0;
        stream.byte_data  = 8'h00;
        #1 rst_n = 1'b0;
        cmpEn = 1'b1;
        idle(2);
        checkResetValues("por");
        #2 rst_n = 1'b1;
        idle(1);

        $display("[TB] Scenario: good load");
        clearSeen();
        pulseStart();
        for (int i = 0; i < 11; i++) applyStimulus(s1[i], 1'b0);
        idle(3);
        checkGoodLoad("good");

        $display("[TB] Scenario: bad checksum");
        clearSeen();
        pulseStart();
        for (int i = 0; i < 10; i++) applyStimulus(s1[i], 1'b0);
        applyStimulus(8'h20, 1'b0);
        idle(3);
        checkOutput("badsum_nwrites",  32'(seenAddr.size()), 32'd2);
        checkOutput("badsum_words",    32'(words_written),   32'd2);
        checkOutput("badsum_error",    32'(error),           32'd1);
        checkOutput("badsum_done",     32'(done),            32'd0);
        checkOutput("badsum_cpu_hold", 32'(cpu_hold),        32'd1);

        $display("[TB] Scenario: header overflow");
        clearSeen();
        pulseStart();
        applyStimulus(8'h3E, 1'b0);
        applyStimulus(8'h03, 1'b0);
        stream.byte_valid = 1'b1;
        stream.byte_data  = 8'hAA;
        idle(5);
        stream.byte_valid = 1'b0;
        checkOutput("ovf_nwrites",    32'(seenAddr.size()),   32'd0);
        checkOutput("ovf_error",      32'(error),             32'd1);
        checkOutput("ovf_byte_ready", 32'(stream.byte_ready), 32'd0);

        $display("[TB] Scenario: good load with stream gaps");
        clearSeen();
        pulseStart();
        for (int i = 0; i < 11; i++) applyStimulus(s1[i], 1'b1);
        idle(3);
        checkGoodLoad("gaps");

        $display("[TB] Scenario: zero-count load");
        clearSeen();
        pulseStart();
        applyStimulus(8'h05, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h05, 1'b0);
        idle(3);
        checkOutput("zero_nwrites",  32'(seenAddr.size()), 32'd0);
        checkOutput("zero_words",    32'(words_written),   32'd0);
        checkOutput("zero_done",     32'(done),            32'd1);
        checkOutput("zero_cpu_hold", 32'(cpu_hold),        32'd0);

        $display("[TB] Scenario: reset mid-session");
        clearSeen();
        pulseStart();
        for (int i = 0; i < 4; i++) applyStimulus(s1[i], 1'b0);
        #2 rst_n = 1'b0;
        #1 checkResetValues("midrst");
        idle(2);
        #2 rst_n = 1'b1;
        idle(1);
        checkOutput("midrst_nwrites", 32'(seenAddr.size()), 32'd0);
        pulseStart();
        for (int i = 0; i < 11; i++) applyStimulus(s1[i], 1'b0);
        idle(3);
        checkGoodLoad("after_rst");

        $display("[TB] Scenario: start pulsed during data");
        clearSeen();
        pulseStart();
        for (int i = 0; i < 4; i++) applyStimulus(s1[i], 1'b0);
        pulseStart();
        for (int i = 4; i < 11; i++) applyStimulus(s1[i], 1'b0);
        idle(3);
        checkGoodLoad("start_in_data");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #200000;
        nChecks++;
        nFail++;
        $display("[TB] FAIL watchdog: simulation time 200000 reached, expected test completion earlier");
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. The fetch stage only reads that memory; this block fills it at boot from a byte stream delivered over a valid/ready handshake.
- Assembles big-endian 32-bit words and writes them to consecutive word addresses starting at a header-supplied base.
- Checks a trailing XOR checksum.
- Drives cpu_hold so the pipeline (PC, IF/ID) is frozen until a load completes successfully.

Parameters:
ADDR_W, 6, instruction-memory word-address width; depth = 2**ADDR_W words (64)

Ports:
clk  input  1  system clock, all state on posedge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse, begins a load session
byte_valid  input  1  byte_data holds a valid byte
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts byte this cycle; transfer = byte_valid & byte_ready
imem_we  output  1  one-cycle instruction-memory write strobe
imem_addr  output  ADDR_W  word address for the write (byte address = imem_addr*4)
imem_wdata  output  32  word to write
words_written  output  ADDR_W+1  words written in current/last session
cpu_hold  output  1  1 = pipeline frozen
done  output  1  sticky: last session passed checksum
error  output  1  sticky: last session failed (overflow or checksum)

Behaviour:
- Reset (async, rst_n=0) forces the following, regardless of state, including mid-session:
  - state IDLE.
  - byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, words_written=0.
  - done=0, error=0, cpu_hold=1.
  - Words already written stay in memory; no partial word is written.
- States: IDLE, HDR_BASE, HDR_CNT, DATA, CHECK, DONE, ERR.
- byte_ready=1 only in HDR_BASE, HDR_CNT, DATA, CHECK; it is registered from state and does not combinationally depend on byte_valid.
- IDLE:
  - start -> HDR_BASE.
  - On entry to HDR_BASE: clear done, error, words_written, the checksum accumulator and the byte-lane counter.
- start in HDR_BASE, HDR_CNT, DATA or CHECK: ignored.
- start in DONE or ERR: same as IDLE (restart).
- Checksum accumulator: 8-bit XOR of every accepted byte before the checksum byte, header bytes included.
- HDR_BASE: accepted byte[ADDR_W-1:0] -> base register; upper bits ignored -> HDR_CNT.
- HDR_CNT: accepted byte = count.
  - If base+count > 2**ADDR_W (computed at ADDR_W+2 bits): -> ERR, no write.
  - Else if count==0: -> CHECK.
  - Else: -> DATA.
- DATA:
  - 2-bit lane counter; first byte -> bits[31:24] … fourth byte -> bits[7:0].
  - On acceptance of the 4th byte: next cycle imem_we=1 for exactly one cycle, with imem_addr=base+words_written (old value) and imem_wdata=assembled word; words_written increments in that same edge.
  - After the count-th word's 4th byte -> CHECK. A byte may be accepted in the same cycle imem_we is high.
  - Gaps (byte_valid=0) are allowed anywhere; state and partial word hold.
- CHECK: accepted byte == accumulator -> DONE, else -> ERR.
- DONE: done=1, cpu_hold=0; holds until start.
- ERR: error=1, cpu_hold=1; holds until start.
- cpu_hold=1 in every state except DONE, so the CPU never runs from reset until a good load.
- imem_addr and imem_wdata keep their last value when imem_we=0.

Test Plan:
- Sequence: reset, start, then stream 19 02 00 22 18 20 01 23 20 22 21.
  - imem_we pulse at addr 25 with data 0x00221820, then at addr 26 with data 0x01232022.
  - words_written=2, done=1, error=0, cpu_hold=0.
- Same stream with checksum byte 20: both writes occur, then error=1, done=0, cpu_hold=1.
- Stream 3E 03: ERR immediately after the count byte; no imem_we; byte_ready=0 afterwards.
- Scenario 1 with byte_valid randomly low ~50% of cycles, including mid-word: identical writes and final flags.
- Stream 05 00 05: DONE with zero imem_we pulses; words_written=0.
- rst_n low after 2 data bytes: all outputs at reset values immediately, no write. Then start followed by scenario 1: clean completion.
- start pulsed during DATA: no effect.
